// File: rtl/exe_stage.sv
// Execute stage: logic/shift/arith/move results, HI/LO pair, single-cycle
// multiply and a 32-step restoring divider that stalls the pipeline.
module exe_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic [2:0]  alu_sel_i,
  input  logic [7:0]  alu_op_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        wreg_i,
  input  logic [4:0]  wd_i,
  input  logic        mt_hi_i,
  input  logic        mt_lo_i,
  input  logic        mf_hi_i,
  input  logic        mf_lo_i,
  output logic        wreg_o,
  output logic [4:0]  wd_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  div_state_t  state_reg, state_next;
  logic [31:0] hi_reg, lo_reg;
  logic [5:0]  count_reg;
  logic [31:0] quo_reg;   // dividend magnitude shifting out, quotient bits shifting in
  logic [31:0] rem_reg;   // partial remainder
  logic [31:0] dvs_reg;   // divisor magnitude
  logic        neg_q_reg, neg_r_reg, dz_reg;

  logic        is_mult, is_div, div_signed, div_start;
  logic [63:0] prod_s, prod_u;
  logic [32:0] rem_shift;
  logic        rem_fits;
  logic [31:0] rem_sub, quo_fin, rem_fin;
  logic [31:0] result;
  logic        result_valid;

  assign is_mult    = (alu_sel_i == 3'd5) && (alu_op_i == 8'h30 || alu_op_i == 8'h31);
  assign is_div     = (alu_sel_i == 3'd5) && (alu_op_i == 8'h32 || alu_op_i == 8'h33);
  assign div_signed = (alu_op_i == 8'h32);
  assign div_start  = (state_reg == IDLE) && is_div && !stall_i;

  assign prod_s = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
  assign prod_u = {32'b0, reg1_i} * {32'b0, reg2_i};

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // A set bit 32 always fits, so the 32-bit difference is exact.
  assign rem_shift = {rem_reg, quo_reg[31]};
  assign rem_fits  = (rem_shift >= {1'b0, dvs_reg});
  assign rem_sub   = rem_shift[31:0] - dvs_reg;

  assign quo_fin = neg_q_reg ? -quo_reg : quo_reg;
  assign rem_fin = neg_r_reg ? -rem_reg : rem_reg;

  // Divider FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Divider FSM next-state logic; a zero divisor skips the iterations
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (div_start) state_next = (reg2_i == 32'b0) ? DONE : BUSY;
      BUSY: if (count_reg == 6'(DIV_CYCLES - 1)) state_next = DONE;
      DONE: if (!stall_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Divider FSM outputs: stall for the issue cycle and every iteration
  always_comb begin
    stall_req_o = 1'b0;
    if (!rst) stall_req_o = div_start || (state_reg == BUSY);
  end

  // Divider datapath: latch magnitudes and signs on issue, iterate while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      dz_reg    <= 1'b0;
    end else if (div_start) begin
      count_reg <= '0;
      rem_reg   <= '0;
      quo_reg   <= (div_signed && reg1_i[31]) ? -reg1_i : reg1_i;
      dvs_reg   <= (div_signed && reg2_i[31]) ? -reg2_i : reg2_i;
      neg_q_reg <= div_signed && (reg1_i[31] ^ reg2_i[31]);
      neg_r_reg <= div_signed && reg1_i[31];
      dz_reg    <= (reg2_i == 32'b0);
    end else if (state_reg == BUSY) begin
      count_reg <= count_reg + 6'd1;
      rem_reg   <= rem_fits ? rem_sub : rem_shift[31:0];
      quo_reg   <= {quo_reg[30:0], rem_fits};
    end
  end

  // HI/LO: divide result first, then multiply, then explicit moves
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (state_reg == DONE) begin
      if (!stall_i && !dz_reg) begin
        hi_reg <= rem_fin;
        lo_reg <= quo_fin;
      end
    end else if (!stall_i) begin
      if (is_mult) begin
        {hi_reg, lo_reg} <= (alu_op_i == 8'h30) ? prod_s : prod_u;
      end else begin
        if (mt_hi_i) hi_reg <= reg1_i;
        if (mt_lo_i) lo_reg <= reg1_i;
      end
    end
  end

  // Combinational result selection; unknown codes yield a non-writing zero
  always_comb begin
    result       = '0;
    result_valid = 1'b1;
    case (alu_sel_i)
      3'd1: case (alu_op_i)
        8'h01:   result = reg1_i & reg2_i;
        8'h02:   result = reg1_i | reg2_i;
        8'h03:   result = reg1_i ^ reg2_i;
        8'h04:   result = ~(reg1_i | reg2_i);
        default: result_valid = 1'b0;
      endcase
      3'd2: case (alu_op_i)
        8'h10:   result = reg2_i << reg1_i[4:0];
        8'h11:   result = reg2_i >> reg1_i[4:0];
        8'h12:   result = $signed(reg2_i) >>> reg1_i[4:0];
        default: result_valid = 1'b0;
      endcase
      3'd3: case (alu_op_i)
        8'h20:   result = reg1_i + reg2_i;
        8'h21:   result = reg1_i - reg2_i;
        8'h22:   result = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
        8'h23:   result = {31'b0, reg1_i < reg2_i};
        default: result_valid = 1'b0;
      endcase
      3'd4: begin
        if (mf_hi_i)      result = hi_reg;
        else if (mf_lo_i) result = lo_reg;
        else              result_valid = 1'b0;
      end
      default: result_valid = 1'b0;
    endcase
  end

  assign wdata_o = rst ? 32'b0 : result;
  assign wreg_o  = !rst && result_valid && wreg_i;
  assign wd_o    = rst ? 5'b0 : wd_i;

endmodule
